char_text_buffer: RTL and testbench

//  Writable, parametrised text-screen buffer that generalises the fixed 16x16 character ROM.

---
 rtl/char_buf_pkg.sv | 14 +
 rtl/char_buf_ram.sv | 29 ++
 rtl/char_text_buffer.sv | 175 +++++++++++++++++
 tb/tb_char_text_buffer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/char_buf_pkg.sv
// Shared constants and FSM state type for the writable text-screen buffer.
// Imported by char_buf_ram, char_text_buffer and the bench.
package char_buf_pkg;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [6:0] CHAR_NL    = 7'h0A;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL_CLR
    } state_t;

endpackage

// File: rtl/char_buf_ram.sv
// Simple dual-port character store: one synchronous write port and one
// registered read port (rdata resets to 0; the array itself is not reset).
// Ports: clk, rst, we/waddr/wdata (write), raddr/rdata (read, 1-clk latency).
module char_buf_ram #(
    parameter int DW = 7,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Same-cycle read of the cell being written returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/char_text_buffer.sv
// COLS x ROWS text-screen buffer with absolute writes, cursor append stream,
// newline/wrap/scroll and a full-screen clear sweep.
// Ports: clk, rst (sync, high); rd_xy -> rd_code (1 clk); wr_valid/wr_ready,
// wr_xy, wr_code; put_valid/put_ready, put_code; clear_req; cur_xy; busy.
module char_text_buffer
    import char_buf_pkg::*;
#(
    parameter int COLS      = 16,
    parameter int ROWS      = 16,
    parameter int CODE_W    = 7,
    parameter int SCROLL_EN = 1,
    localparam int CW = $clog2(COLS),
    localparam int RW = $clog2(ROWS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CW+RW-1:0] rd_xy,
    output logic [CODE_W-1:0] rd_code,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CW+RW-1:0] wr_xy,
    input  logic [CODE_W-1:0] wr_code,
    input  logic             put_valid,
    output logic             put_ready,
    input  logic [CODE_W-1:0] put_code,
    input  logic             clear_req,
    output logic [CW+RW-1:0] cur_xy,
    output logic             busy
);

    localparam int AW = CW + RW;
    localparam logic [AW-1:0] CELL_LAST = AW'(COLS * ROWS - 1);
    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CODE_W-1:0] SP    = CODE_W'(CHAR_SPACE);
    localparam logic [CODE_W-1:0] NL    = CODE_W'(CHAR_NL);

    state_t state, nstate;

    logic [AW-1:0] cnt;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] top_row;

    logic wr_fire, put_fire;
    logic put_nl, put_wrap, put_last;
    logic scroll_go, clr_end, scr_end;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [CODE_W-1:0] ram_wdata;
    logic [AW-1:0]     ram_raddr;

    assign wr_fire  = wr_valid && wr_ready;
    assign put_fire = put_valid && put_ready;
    assign put_nl   = (put_code == NL);
    assign put_wrap = put_nl || (cur_col == COL_LAST);
    assign put_last = (cur_row == ROW_LAST);
    assign scroll_go = put_fire && put_wrap && put_last
                    && (SCROLL_EN != 0);
    assign clr_end  = (cnt == CELL_LAST);
    assign scr_end  = (cnt[CW-1:0] == COL_LAST);

    assign cur_xy = {cur_row, cur_col};

    // Logical rows are rotated by top_row so scrolling never moves data.
    assign ram_raddr = {rd_xy[AW-1:CW] + top_row, rd_xy[CW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR;
        else     state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            CLEAR:      if (clr_end)   nstate = IDLE;
            IDLE:       if (scroll_go) nstate = SCROLL_CLR;
            SCROLL_CLR: if (scr_end)   nstate = IDLE;
            default:                   nstate = CLEAR;
        endcase
        if (clear_req) nstate = CLEAR;
    end

    always_comb begin
        busy      = (state != IDLE);
        wr_ready  = (state == IDLE) && !clear_req && !rst;
        put_ready = wr_ready && !wr_valid;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = SP;
        unique case (state)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
            end
            SCROLL_CLR: begin
                // top_row already advanced: new last row is top_row-1.
                ram_we    = 1'b1;
                ram_waddr = {top_row + ROW_LAST, cnt[CW-1:0]};
            end
            IDLE: begin
                if (wr_fire) begin
                    ram_we    = 1'b1;
                    ram_waddr = {wr_xy[AW-1:CW] + top_row,
                                 wr_xy[CW-1:0]};
                    ram_wdata = wr_code;
                end else if (put_fire && !put_nl) begin
                    ram_we    = 1'b1;
                    ram_waddr = {cur_row + top_row, cur_col};
                    ram_wdata = put_code;
                end
            end
            default: ;
        endcase
        if (rst) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            cur_row <= '0;
            cur_col <= '0;
            top_row <= '0;
        end else if (clear_req) begin
            cnt <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (clr_end) begin
                        top_row <= '0;
                        cur_row <= '0;
                        cur_col <= '0;
                    end
                end
                SCROLL_CLR: begin
                    cnt <= scr_end ? '0 : cnt + 1'b1;
                end
                IDLE: begin
                    if (put_fire) begin
                        if (put_wrap) begin
                            cur_col <= '0;
                            if (!put_last) begin
                                cur_row <= cur_row + 1'b1;
                            end else if (SCROLL_EN != 0) begin
                                top_row <= top_row + 1'b1;
                                cnt     <= '0;
                            end else begin
                                cur_row <= '0;
                            end
                        end else begin
                            cur_col <= cur_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    char_buf_ram #(
        .DW (CODE_W),
        .AW (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (rd_code)
    );

endmodule

// File: tb/tb_char_text_buffer.sv
// Scoreboard bench for char_text_buffer (16x16, SCROLL_EN=1).
// Reads push expected codes; a negedge monitor pops and compares rd_code.
module tb_char_text_buffer;
    import char_buf_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] rd_xy, wr_xy, cur_xy;
    logic [6:0] rd_code, wr_code, put_code;
    logic       wr_valid, wr_ready, put_valid, put_ready;
    logic       clear_req, busy;

    char_text_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .rd_xy     (rd_xy),
        .rd_code   (rd_code),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_xy     (wr_xy),
        .wr_code   (wr_code),
        .put_valid (put_valid),
        .put_ready (put_ready),
        .put_code  (put_code),
        .clear_req (clear_req),
        .cur_xy    (cur_xy),
        .busy      (busy)
    );

    typedef struct {
        int         due;
        logic [6:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (rd_code !== e.exp) begin
                errors++;
                $display("FAIL rd %s got %h exp %h",
                         e.name, rd_code, e.exp);
            end
        end
    end

    initial begin
        #100us;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", n, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] xy, input logic [6:0] e,
                      input string n);
        rd_xy = xy;
        sb.push_back('{cyc + 1, e, n});
        tick();
    endtask

    task automatic wait_rdy(input bit is_put);
        int n = 0;
        #1;
        while (!(is_put ? put_ready : wr_ready) && n < 400) begin
            tick();
            #1;
            n++;
        end
        if (n >= 400) chk(is_put ? "put_rdy_to" : "wr_rdy_to", 0, 1);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] xy, input logic [6:0] c);
        wr_xy    = xy;
        wr_code  = c;
        wr_valid = 1'b1;
        wait_rdy(1'b0);
        wr_valid = 1'b0;
    endtask

    task automatic put(input logic [6:0] c);
        put_code  = c;
        put_valid = 1'b1;
        wait_rdy(1'b1);
        put_valid = 1'b0;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
    endtask

    int n;

    initial begin
        rst = 1'b1;
        rd_xy = '0; wr_xy = '0; wr_code = '0; put_code = '0;
        wr_valid = 1'b0; put_valid = 1'b0; clear_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1) reset state and initial clear sweep
        chk("rst_rd_code", rd_code, 0);
        chk("rst_cur_xy", cur_xy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_put_ready", put_ready, 0);
        chk("rst_busy", busy, 1);
        busy_len(n);
        chk("clear_len", n, 256);
        chk("idle_wr_ready", wr_ready, 1);
        rd(8'h00, 7'h20, "blank00");
        rd(8'h35, 7'h20, "blank35");
        rd(8'h7A, 7'h20, "blank7A");
        rd(8'hFF, 7'h20, "blankFF");

        // 2) absolute write; cursor stays home
        wr(8'h35, "K");
        rd(8'h35, "K", "wrK");
        chk("wr_cur_xy", cur_xy, 0);
        // read/write collision returns the old value
        rd_xy = 8'h35;
        wr_xy = 8'h35; wr_code = "Z"; wr_valid = 1'b1;
        sb.push_back('{cyc + 1, "K", "coll_old"});
        #1;
        chk("coll_ready", wr_ready, 1);
        tick();
        wr_valid = 1'b0;
        rd(8'h35, "Z", "coll_new");

        // 3) append stream with newline
        put("A"); put("B"); put(CHAR_NL); put("C");
        rd(8'h00, "A", "putA");
        rd(8'h01, "B", "putB");
        rd(8'h10, "C", "putC");
        rd(8'h02, 7'h20, "nl_not_stored");
        chk("put_cur_xy", cur_xy, 8'h11);

        // 4) fill row 15 and scroll
        for (int i = 0; i < 14; i++) put(CHAR_NL);
        chk("row15_cur", cur_xy, 8'hF0);
        for (int i = 0; i < 16; i++) put(7'(8'h61 + i));
        chk("scroll_busy", busy, 1);
        busy_len(n);
        chk("scroll_len", n, 16);
        chk("scroll_cur", cur_xy, 8'hF0);
        rd(8'h00, "C", "scr_row0");
        rd(8'h01, 7'h20, "scr_row0b");
        rd(8'h25, "Z", "scr_row2");
        rd(8'hE0, "a", "scr_rowE_0");
        rd(8'hEF, "p", "scr_rowE_F");
        rd(8'hF0, 7'h20, "scr_rowF_0");
        rd(8'hF7, 7'h20, "scr_rowF_7");
        rd(8'hFF, 7'h20, "scr_rowF_F");

        // 6) write has priority over put in the same cycle
        wr_xy = 8'h22; wr_code = "W"; wr_valid = 1'b1;
        put_code = "Q"; put_valid = 1'b1;
        #1;
        chk("pri_wr_ready", wr_ready, 1);
        chk("pri_put_ready", put_ready, 0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("pri_put_next", put_ready, 1);
        tick();
        put_valid = 1'b0;
        rd(8'h22, "W", "pri_wr");
        rd(8'hF0, "Q", "pri_put");
        chk("pri_cur", cur_xy, 8'hF1);

        // 5) clear_req in the middle of a scroll sweep
        put(CHAR_NL);
        chk("scr2_busy", busy, 1);
        repeat (3) tick();
        clear_req = 1'b1;
        wr_valid  = 1'b1;
        #1;
        chk("clr_wr_ready", wr_ready, 0);
        tick();
        clear_req = 1'b0;
        wr_valid  = 1'b0;
        busy_len(n);
        chk("reclear_len", n, 256);
        chk("reclear_cur", cur_xy, 0);
        for (int i = 0; i < 256; i++) rd(8'(i), 7'h20, "reclear");

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
